// File: rtl/exec_sequencer.sv
// Multi-cycle execute sequencer between the LEGv8 R-type decoder and the ALU/register file.
// It accepts one instruction at a time, pulses alu_start, and waits out MUL/DIV before a single write-back.
module exec_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [9:0] opcode,
  input  logic       flush,
  output logic       instr_ready,
  output logic [2:0] alu_op,
  output logic       alu_start,
  output logic       reg_write_rf,
  output logic       stall,
  output logic       illegal
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WB} state_t;

  localparam logic [9:0] OPC_ADD = 10'b1000101000;
  localparam logic [9:0] OPC_SUB = 10'b1100101100;
  localparam logic [9:0] OPC_DIV = 10'b0000011111;
  localparam logic [9:0] OPC_MUL = 10'b1111100000;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_DIV  = 3'b011;
  localparam logic [2:0] ALU_MUL  = 3'b100;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             alu_start_q, alu_start_d;
  logic             wr_q, wr_d;
  logic             illegal_q, illegal_d;

  logic             dec_legal;
  logic             dec_multi;
  logic [2:0]       dec_op;
  logic [CNT_W-1:0] dec_cnt;

  always_comb begin
    dec_legal = 1'b1;
    dec_multi = 1'b0;
    dec_op    = ALU_IDLE;
    dec_cnt   = '0;
    case (opcode)
      OPC_ADD: dec_op = ALU_ADD;
      OPC_SUB: dec_op = ALU_SUB;
      OPC_DIV: begin dec_op = ALU_DIV; dec_multi = 1'b1; dec_cnt = DIV_LOAD; end
      OPC_MUL: begin dec_op = ALU_MUL; dec_multi = 1'b1; dec_cnt = MUL_LOAD; end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_op_d    = alu_op_q;
    alu_start_d = 1'b0;
    wr_d        = 1'b0;
    illegal_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        alu_op_d = ALU_IDLE;
        cnt_d    = '0;
        if (instr_valid) begin
          if (!dec_legal) begin
            illegal_d = 1'b1;
          end else if (dec_multi) begin
            state_d     = S_WAIT;
            cnt_d       = dec_cnt;
            alu_op_d    = dec_op;
            alu_start_d = 1'b1;
          end else begin
            state_d     = S_WB;
            alu_op_d    = dec_op;
            alu_start_d = 1'b1;
            wr_d        = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d  = S_IDLE;
          alu_op_d = ALU_IDLE;
          cnt_d    = '0;
        end else if (cnt_q == '0) begin
          state_d = S_WB;
          wr_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WB: begin
        state_d  = S_IDLE;
        alu_op_d = ALU_IDLE;
        cnt_d    = '0;
      end
      default: begin
        state_d  = S_IDLE;
        alu_op_d = ALU_IDLE;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alu_op_q    <= ALU_IDLE;
      alu_start_q <= 1'b0;
      wr_q        <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_op_q    <= alu_op_d;
      alu_start_q <= alu_start_d;
      wr_q        <= wr_d;
      illegal_q   <= illegal_d;
    end
  end

  assign instr_ready  = (state_q == S_IDLE);
  assign stall        = !instr_ready;
  assign alu_op       = alu_op_q;
  assign alu_start    = alu_start_q;
  // A flush arriving during write-back suppresses the write in that same cycle.
  assign reg_write_rf = wr_q & ~flush;
  assign illegal      = illegal_q;

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle execute sequencer placed between the opcode decoder and the ALU / register file.
- Accepts one decoded LEGv8 R-type instruction at a time over a valid/ready handshake.
- Drives alu_op and a one-cycle ALU start pulse, holds the front end stalled for the multi-cycle ops (MUL, DIV), then issues exactly one register-file write per completed instruction.
- ADD and SUB complete in a single cycle.

Parameters:
- MUL_CYCLES, 4, number of cycles the ALU needs for a multiply; legal range 1..2^CNT_W-1.
- DIV_CYCLES, 8, number of cycles the ALU needs for a divide; legal range 1..2^CNT_W-1.
- CNT_W, 4, width of the internal wait counter.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  opcode is valid this cycle.
- opcode  in  10  instruction opcode field [31:22].
- flush  in  1  synchronous abort of the in-flight instruction.
- instr_ready  out  1  sequencer can accept an instruction.
- alu_op  out  3  ALU operation: 010 ADD, 001 SUB, 011 DIV, 100 MUL, 000 idle.
- alu_start  out  1  one-cycle pulse telling the ALU to begin.
- reg_write_rf  out  1  register-file write enable, one-cycle pulse.
- stall  out  1  hold fetch/decode; high whenever an instruction is in flight.
- illegal  out  1  one-cycle pulse when an unsupported opcode is accepted.

Behaviour:
- Opcode map:
  - 1000101000 = ADD (alu_op 010)
  - 1100101100 = SUB (001)
  - 0000011111 = DIV (011)
  - 1111100000 = MUL (100)
  - every other value is illegal.
- States: IDLE, WAIT, WB.
- Reset:
  - rst_n low forces state=IDLE, counter=0, alu_op=000, alu_start=0, reg_write_rf=0, illegal=0.
  - Registered outputs are all 0.
  - instr_ready=1 and stall=0, since both are decoded directly from state==IDLE.
- Handshake:
  - A transfer occurs on a rising edge where instr_valid && instr_ready.
  - opcode is sampled on that edge only.
  - instr_valid while instr_ready=0 is ignored: no queueing and no side effects.
- Acceptance at edge k, ADD/SUB:
  - At cycle k+1: state=WB, alu_op=code, alu_start=1, reg_write_rf=1.
  - At cycle k+2: state=IDLE, alu_op=000.
  - Latency 1. The next instruction can be accepted at edge k+2.
- Acceptance at edge k, MUL/DIV, with N = MUL_CYCLES or DIV_CYCLES:
  - At cycle k+1: state=WAIT, counter=N-1, alu_op=code, alu_start=1.
  - Each following cycle in WAIT decrements the counter. WAIT occupies cycles k+1..k+N.
  - When counter==0 in WAIT, the next state is WB.
  - WB is at cycle k+N+1 with reg_write_rf=1 and alu_op still held. IDLE follows at k+N+2.
  - alu_start is high only in the first WAIT cycle.
- Illegal opcode accepted at edge k:
  - At cycle k+1: illegal=1 and state remains IDLE; all other outputs stay 0.
  - instr_ready stays 1, so a back-to-back accept is allowed.
- stall = (state != IDLE). instr_ready = !stall.
- flush:
  - Sampled while in WAIT or WB, it forces state=IDLE and alu_op=000 on the next edge, with counter cleared.
  - If flush is high in the WB cycle, reg_write_rf is gated to 0 in that same cycle (combinational gate), so no write occurs.
  - flush in IDLE has no effect and does not block a simultaneous accept.
- Asynchronous reset mid-operation: the in-flight instruction is discarded, no write occurs, and all outputs take their reset values immediately.
- Invariants:
  - Exactly one reg_write_rf pulse per accepted legal, unflushed instruction.
  - Never more than one instruction in flight.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle -> alu_op=000, stall=0, instr_ready=1, reg_write_rf=0 immediately; release -> block idle.
- Back-to-back ADD: ADD at edge 0, SUB at edge 2 -> reg_write_rf high at cycles 1 and 3, alu_op 010 then 001, stall high only in cycles 1 and 3.
- MUL with MUL_CYCLES=4: accept at edge 0 -> alu_start at cycle 1 only, stall high cycles 1–5, reg_write_rf only at cycle 5, alu_op=100 throughout 1–5. Also hold instr_valid high during cycles 1–5 -> no further accept.
- DIV with flush: DIV_CYCLES=8, accept at edge 0, flush=1 during cycle 3 -> IDLE at cycle 4, no reg_write_rf pulse, instr_ready=1 at cycle 4.
- Illegal opcode: accept opcode 0000000000 at edge 0 -> illegal=1 at cycle 1, reg_write_rf never high, stall stays 0; ADD accepted at edge 1 writes at cycle 2.
- Reset mid-WAIT: DIV accepted, rst_n pulsed low at cycle 4 -> no reg_write_rf pulse ever; the next MUL after release completes with normal latency (MUL_CYCLES+1).
